// File: rtl/ble_cmd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ble_cmd_responder_pkg
// Description : Shared opcodes, response codes and state types for the
//               command link responder.
// Revision    : 1.0 - initial release
// ============================================================================
package ble_cmd_responder_pkg;

    localparam logic [15:0] CALIBRATE     = 16'h2000;
    localparam logic [15:0] MOVE          = 16'h4000;
    localparam logic [15:0] TOUR          = 16'h6000;
    localparam logic [7:0]  COMM_COMPLETE = 8'hA5;

    typedef enum logic [0:0] {
        IDLE_HI = 1'b0,
        WAIT_LO = 1'b1
    } rx_asm_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_bit_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Full 8N1 frame, bit 0 goes on the line first.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ble_cmd_responder_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_rx
// Description : 8N1 byte receiver with two-flop synchroniser and mid-bit
//               sampling; flags framing errors and start-bit detection.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import ble_cmd_responder_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frm_err,
    output logic       start_det,
    output logic       busy
);

    localparam int                 c_cnt_w = $clog2(BAUD_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(BAUD_DIV / 2);

    logic               sync1_q, sync2_q, prev_q;
    rx_bit_t            state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               byte_rdy_q, byte_rdy_d;
    logic               frm_err_q, frm_err_d;
    logic               start_det_q, start_det_d;
    logic               w_fall, w_tick;

    assign w_fall = prev_q & ~sync2_q;
    // A sample is taken on the clock where the counter has run down to 1.
    assign w_tick = (cnt_q == c_cnt_w'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_rdy_d  = 1'b0;
        frm_err_d   = 1'b0;
        start_det_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (w_fall) begin
                    state_d     = RX_START;
                    cnt_d       = c_half;
                    start_det_d = 1'b1;
                end
            end
            RX_START: begin
                if (w_tick) begin
                    if (sync2_q) begin
                        state_d = RX_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d   = RX_DATA;
                        cnt_d     = c_full;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (w_tick) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = c_full;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    state_d    = RX_IDLE;
                    cnt_d      = '0;
                    byte_rdy_d = sync2_q;
                    frm_err_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_rdy_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            start_det_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_rdy_q  <= byte_rdy_d;
            frm_err_q   <= frm_err_d;
            start_det_q <= start_det_d;
        end
    end

    assign byte_rdy  = byte_rdy_q;
    assign rx_byte   = shift_q;
    assign frm_err   = frm_err_q;
    assign start_det = start_det_q;
    assign busy      = (state_q != RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/ble_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : ble_cmd_responder
// Description : Serial command link endpoint: assembles two RX bytes into a
//               16-bit command and serialises response bytes on TX.
// Revision    : 1.0 - initial release
// ============================================================================
module ble_cmd_responder
    import ble_cmd_responder_pkg::*;
#(
    parameter int BAUD_DIV    = 5208,
    parameter int GAP_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done,
    output logic        frm_err
);

    localparam int                 c_gap_w   = $clog2(GAP_TIMEOUT + 1);
    localparam logic [c_gap_w-1:0] c_gap_max = c_gap_w'(GAP_TIMEOUT);
    localparam int                 c_cnt_w   = $clog2(BAUD_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_bit_end = c_cnt_w'(BAUD_DIV - 1);

    logic       w_byte_rdy, w_frm_err, w_start_det, w_rx_busy;
    logic [7:0] w_rx_byte;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_rdy  (w_byte_rdy),
        .rx_byte   (w_rx_byte),
        .frm_err   (w_frm_err),
        .start_det (w_start_det),
        .busy      (w_rx_busy)
    );

    rx_asm_t            asm_q, asm_d;
    logic [7:0]         hi_q, hi_d;
    logic [15:0]        cmd_q, cmd_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic [c_gap_w-1:0] gap_q, gap_d;

    always_comb begin
        asm_d     = asm_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        gap_d     = gap_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (asm_q)
            IDLE_HI: begin
                if (w_start_det) begin
                    cmd_rdy_d = 1'b0;
                end
                if (w_byte_rdy) begin
                    hi_d  = w_rx_byte;
                    gap_d = '0;
                    asm_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (w_byte_rdy) begin
                    cmd_d     = {hi_q, w_rx_byte};
                    cmd_rdy_d = 1'b1;
                    asm_d     = IDLE_HI;
                end else if (w_frm_err) begin
                    asm_d = IDLE_HI;
                end else if (!w_rx_busy) begin
                    // Gap timer only runs while no low byte is in flight.
                    if (gap_q >= c_gap_max) begin
                        asm_d = IDLE_HI;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: asm_d = IDLE_HI;
        endcase
    end

    tx_state_t          tx_state_q, tx_state_d;
    logic [9:0]         tx_shift_q, tx_shift_d;
    logic [3:0]         tx_bits_q, tx_bits_d;
    logic [c_cnt_w-1:0] tx_cnt_q, tx_cnt_d;
    logic               tx_q, tx_d;
    logic               tx_done_q, tx_done_d;
    logic [9:0]         w_frame;

    assign w_frame = tx_frame(resp);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bits_d  = tx_bits_q;
        tx_cnt_d   = tx_cnt_q;
        tx_d       = tx_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (trmt) begin
                    tx_state_d = TX_SEND;
                    tx_d       = w_frame[0];
                    tx_shift_d = {1'b1, w_frame[9:1]};
                    tx_bits_d  = 4'd9;
                    tx_cnt_d   = c_bit_end;
                    tx_done_d  = 1'b0;
                end
            end
            TX_SEND: begin
                if (tx_cnt_q == '0) begin
                    if (tx_bits_q == 4'd0) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[9:1]};
                        tx_bits_d  = tx_bits_q - 4'd1;
                        tx_cnt_d   = c_bit_end;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q      <= IDLE_HI;
            hi_q       <= 8'h00;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            gap_q      <= '0;
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 10'h3FF;
            tx_bits_q  <= 4'd0;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            asm_q      <= asm_d;
            hi_q       <= hi_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            gap_q      <= gap_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bits_q  <= tx_bits_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;
    assign frm_err = w_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_ble_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ble_cmd_responder
// Description : Directed self-checking bench for ble_cmd_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ble_cmd_responder;
    import ble_cmd_responder_pkg::*;

    localparam int BAUD     = 16;
    localparam int GAP      = 200;
    localparam int IDLE_GAP = 4;
    localparam int FRAME    = 10 * BAUD;

    logic        clk, rst, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done, frm_err;
    logic [15:0] cmd;
    logic [7:0]  resp;

    int n_checks = 0;
    int n_fail   = 0;

    ble_cmd_responder #(
        .BAUD_DIV    (BAUD),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .frm_err     (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // TX model: a frame starts on the edge that accepts trmt and lasts FRAME clocks.
    int unsigned m_edge = 0;
    int unsigned m_start = 0;
    bit          m_started = 1'b0;
    logic [9:0]  m_frame = 10'h3FF;

    always @(posedge clk) begin
        m_edge++;
        if (rst) begin
            m_started = 1'b0;
        end else if (trmt && !(m_started && (m_edge - m_start) <= FRAME)) begin
            m_started = 1'b1;
            m_start   = m_edge;
            m_frame   = {1'b1, resp, 1'b0};
        end
    end

    always @(negedge clk) begin
        logic        exp_tx, exp_done;
        int unsigned off;
        if (rst || !m_started) begin
            exp_tx   = 1'b1;
            exp_done = 1'b0;
        end else begin
            off = m_edge - m_start;
            if (off < FRAME) begin
                exp_tx   = m_frame[off / BAUD];
                exp_done = 1'b0;
            end else begin
                exp_tx   = 1'b1;
                exp_done = 1'b1;
            end
        end
        check("tx line", {31'd0, TX}, {31'd0, exp_tx});
        check("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
    end

    // Drives one frame on RX and records when cmd_rdy is first seen high.
    task automatic send_byte(input logic [7:0] b, input logic stop,
                             output int rdy_at, output int ferr_n, output logic rdy_end);
        logic [9:0] f;
        f      = {stop, b, 1'b0};
        rdy_at = -1;
        ferr_n = 0;
        for (int k = 0; k < FRAME + IDLE_GAP; k++) begin
            @(negedge clk);
            if (cmd_rdy && rdy_at < 0) rdy_at = k;
            if (frm_err) ferr_n++;
            RX = (k < FRAME) ? f[k / BAUD] : 1'b1;
        end
        rdy_end = cmd_rdy;
    endtask

    task automatic send_cmd(input string name, input logic [7:0] hi, input logic [7:0] lo);
        int   r, fe;
        logic re;
        send_byte(hi, 1'b1, r, fe, re);
        check({name, " no rdy after hi"}, {31'd0, re}, 32'd0);
        send_byte(lo, 1'b1, r, fe, re);
        check({name, " rdy in stop bit"}, {31'd0, (r >= 9 * BAUD && r < FRAME)}, 32'd1);
        check({name, " cmd"}, {16'd0, cmd}, {16'd0, hi, lo});
        check({name, " no frm_err"}, fe, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r, fe;
        logic       re;
        logic [9:0] exp_bits;
        exp_bits    = 10'b11_0100_1010;
        RX          = 1'b1;
        trmt        = 1'b0;
        resp        = 8'h00;
        clr_cmd_rdy = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset TX", {31'd0, TX}, 32'd1);
        check("reset cmd", {16'd0, cmd}, 32'd0);
        check("reset cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("reset tx_done", {31'd0, tx_done}, 32'd0);
        check("reset frm_err", {31'd0, frm_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic command and acknowledge
        send_cmd("t1", 8'h20, 8'h00);
        check("t1 cmd literal", {16'd0, cmd}, {16'd0, CALIBRATE});
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("t1 clr cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t1 cmd held", {16'd0, cmd}, 32'h2000);

        // Response transmit with a trmt retry in the middle of the frame
        resp = COMM_COMPLETE;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        for (int j = 0; j < 170; j++) begin
            if (j % BAUD == BAUD / 2 && j < FRAME)
                check("t2 tx bit literal", {31'd0, TX}, {31'd0, exp_bits[j / BAUD]});
            if (j == FRAME - 1) check("t2 tx_done low at 159", {31'd0, tx_done}, 32'd0);
            if (j == FRAME)     check("t2 tx_done high at 160", {31'd0, tx_done}, 32'd1);
            trmt = (j == 40);
            resp = (j == 40) ? 8'h00 : COMM_COMPLETE;
            @(negedge clk);
        end
        trmt = 1'b0;

        // Orphaned high byte discarded by the gap timeout
        send_byte(8'h5A, 1'b1, r, fe, re);
        check("t3 no rdy after 5A", {31'd0, re}, 32'd0);
        repeat (GAP + 60) @(negedge clk);
        send_cmd("t3", 8'h12, 8'h34);

        // cmd_rdy cleared by a new high byte, then a framing error
        send_byte(8'h99, 1'b1, r, fe, re);
        check("t4 rdy cleared by new hi", {31'd0, re}, 32'd0);
        check("t4 cmd holds", {16'd0, cmd}, 32'h1234);
        send_byte(8'h3C, 1'b0, r, fe, re);
        check("t4 frm_err pulses once", fe, 32'd1);
        check("t4 no rdy on bad stop", r, 32'hFFFF_FFFF);
        send_cmd("t4", 8'hAB, 8'hCD);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;

        // Short low glitch on RX
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        fe = 0;
        r  = 0;
        for (int k = 0; k < 3 * BAUD; k++) begin
            @(negedge clk);
            if (frm_err) fe++;
            if (cmd_rdy) r++;
        end
        check("t5 glitch no frm_err", fe, 32'd0);
        check("t5 glitch no cmd_rdy", r, 32'd0);
        send_cmd("t5", 8'h55, 8'h66);

        // Asynchronous reset mid TX and mid RX
        resp = COMM_COMPLETE;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j == 38) RX = 1'b0;
            @(negedge clk);
        end
        check("t6 TX low before reset", {31'd0, TX}, 32'd0);
        check("t6 cmd_rdy before reset", {31'd0, cmd_rdy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6 async TX", {31'd0, TX}, 32'd1);
        check("t6 async cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        check("t6 async tx_done", {31'd0, tx_done}, 32'd0);
        check("t6 async cmd", {16'd0, cmd}, 32'd0);
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_cmd("t6", 8'h43, 8'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
